// File: rtl/dm_pkg.sv
// dm_pkg: access-size codes, FSM state type and decode helpers shared by the data-memory controller
package dm_pkg;
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dm_state_t;

  function automatic logic dm_is_half(input logic [2:0] t);
    return t == DM_HALF || t == DM_HALF_U;
  endfunction

  function automatic logic dm_bad_type(input logic [2:0] t);
    return t > DM_BYTE_U;
  endfunction
endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port word RAM with synchronous read and per-byte write enables (contents never reset)
module dm_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           i_re,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);
  logic [3:0][7:0] r_mem [DEPTH_WORDS];
  logic [31:0]     r_q;

  // byte-lane writes and registered read; output holds until the next read
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (i_be[b]) r_mem[i_idx][b] <= i_wdata[8*b +: 8];
    if (i_re) r_q <= r_mem[i_idx];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: request/response load-store controller over dm_ram; define DM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  dm_state_t   r_state, w_next;
  logic        r_write;
  logic [2:0]  r_type;
  logic [AW+1:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_accept, w_half, w_word, w_err, w_re, w_unused;
  logic [1:0]  w_off;
  logic [3:0]  w_lanes, w_be;
  logic [31:0] w_q, w_sh, w_ld;

  assign w_unused = &{1'b0, addr[31:AW+2]};
  assign req_ready = r_state == IDLE;
  assign w_accept = req_valid & req_ready;
  assign w_half = dm_is_half(r_type);
  assign w_word = r_type == DM_WORD;
`ifdef DM_MISALIGN_TRAP_EN
  assign w_err = dm_bad_type(r_type) | (w_half & r_addr[0]) | (w_word & |r_addr[1:0]);
  assign w_off = r_addr[1:0];
`else
  assign w_err = dm_bad_type(r_type);
  assign w_off = w_word ? 2'b00 : w_half ? {r_addr[1], 1'b0} : r_addr[1:0];
`endif
  assign w_lanes = w_word ? 4'hF : w_half ? 4'h3 << w_off : 4'h1 << w_off;
  assign w_re = r_state == ACCESS && !r_write && !w_err;
  assign w_be = (r_state == ACCESS && r_write && !w_err) ? w_lanes : 4'h0;
  assign w_sh = w_q >> {w_off, 3'b000};
  assign w_ld = r_type == DM_WORD  ? w_sh :
                r_type == DM_HALF   ? {{16{w_sh[15]}}, w_sh[15:0]} :
                r_type == DM_HALF_U ? {16'h0, w_sh[15:0]} :
                r_type == DM_BYTE   ? {{24{w_sh[7]}}, w_sh[7:0]} :
                                      {24'h0, w_sh[7:0]};
  assign rsp_valid = r_state == RESP;
  assign rsp_err = rsp_valid & w_err;
  assign rdata = (rsp_valid && !r_write && !w_err) ? w_ld : 32'h0;

  dm_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_re    (w_re),
    .i_be    (w_be),
    .i_idx   (r_addr[AW+1:2]),
    .i_wdata (r_wdata << {w_off, 3'b000}),
    .o_rdata (w_q)
  );

  // state register; reset drops any access or response in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  end

  // request fields are captured once, on acceptance, and held through the response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_write <= 1'b0;
      r_type <= DM_WORD;
      r_addr <= '0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_write <= mem_write;
      r_type <= dm_type;
      r_addr <= addr[AW+1:0];
      r_wdata <= wdata;
    end
  end

  // IDLE -> ACCESS on handshake, ACCESS -> RESP always, RESP -> IDLE when consumed
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_accept ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = RESP;
    else w_next = rsp_ready ? IDLE : RESP;
  end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed and random load/store traffic checked against a byte-array memory model
module tb_dm_ctrl;
  localparam int DEPTH = 256;

  logic        clk, rstn, req_valid, req_ready, mem_write, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  dm_type;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  mb [4*DEPTH];
  int          total, bad;

  dm_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_write (mem_write),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rdata     (rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference: byte-addressed memory, size/extension from arithmetic on the access rules
  function automatic logic [31:0] mdl(input logic w, input logic [2:0] t, input logic [31:0] a,
                                      input logic [31:0] d, output logic err);
    int sz, ba;
    longint v;
    sz = t == 0 ? 4 : (t == 1 || t == 2) ? 2 : 1;
    ba = int'(a % (4 * DEPTH));
    err = t > 4;
`ifdef DM_MISALIGN_TRAP_EN
    if (ba % sz != 0) err = 1;
`endif
    ba = ba - ba % sz;
    if (err) return 0;
    if (w) begin
      for (int i = 0; i < sz; i++) mb[ba+i] = d[8*i +: 8];
      return 0;
    end
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(mb[ba+i]) << (8 * i);
    if ((t == 1 || t == 3) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  // one full transaction starting and ending on a falling edge; hold = cycles rsp_ready stays low in RESP
  task automatic txn(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                     input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_d;
    logic        exp_e;
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; mem_write = w; dm_type = t; addr = a; wdata = d; rsp_ready = hold == 0;
    exp_d = mdl(w, t, a, d, exp_e);
    @(negedge clk);
    req_valid = 0; mem_write = 1'($urandom()); dm_type = 3'($urandom()); addr = $urandom(); wdata = $urandom();
    chk("access_rsp_valid", rsp_valid, 0);
    chk("access_req_ready", req_ready, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rdata", rdata, exp_d);
    chk("rsp_err", rsp_err, exp_e);
    rd = rdata; er = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rdata", rdata, rd);
      chk("hold_rsp_err", rsp_err, er);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [31:0] rd, r0, r4;
    logic        er, e;
    total = 0; bad = 0;
    foreach (mb[i]) mb[i] = 8'h0;
    rstn = 0; req_valid = 0; mem_write = 0; dm_type = 0; addr = 0; wdata = 0; rsp_ready = 0;
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < DEPTH; i++) txn(1, 3'd0, 32'(4 * i), $urandom(), 0, rd, er);

    txn(1, 3'd0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    txn(0, 3'd1, 32'h12, 0, 0, rd, er);
    chk("half_signed", rd, 32'hFFFFDEAD);
    txn(0, 3'd2, 32'h12, 0, 1, rd, er);
    chk("half_unsigned", rd, 32'h0000DEAD);

    txn(1, 3'd0, 32'h20, 32'h0, 0, rd, er);
    txn(1, 3'd3, 32'h21, 32'hFFFFFF80, 0, rd, er);
    txn(0, 3'd3, 32'h21, 0, 0, rd, er);
    chk("byte_signed", rd, 32'hFFFFFF80);
    txn(0, 3'd4, 32'h21, 0, 0, rd, er);
    chk("byte_unsigned", rd, 32'h00000080);
    txn(0, 3'd0, 32'h20, 0, 0, rd, er);
    chk("byte_in_word", rd, 32'h00008000);

    txn(0, 3'd1, 32'h10, 0, 5, rd, er);

    txn(0, 3'd0, 32'h0, 0, 0, r0, er);
    txn(0, 3'd0, 32'h2, 0, 0, rd, er);
`ifdef DM_MISALIGN_TRAP_EN
    chk("misalign_err", er, 1);
    chk("misalign_rdata", rd, 0);
`else
    chk("align_word", rd, r0);
`endif
    txn(1, 3'd0, 32'h2, 32'hA5A5A5A5, 0, rd, er);
    txn(0, 3'd0, 32'h0, 0, 0, rd, er);

    txn(1, 3'd7, 32'h4, 32'h11111111, 0, rd, er);
    chk("bad_type_err", er, 1);
    txn(0, 3'd7, 32'h4, 0, 0, rd, er);
    chk("bad_type_rdata", rd, 0);
    txn(0, 3'd0, 32'h4, 0, 0, r4, er);
    txn(0, 3'd0, 32'(4 * DEPTH + 4), 0, 0, rd, er);
    chk("wrap_word", rd, r4);

    txn(0, 3'd0, 32'h50, 0, 0, r0, er);
    txn(1, 3'd0, 32'h50, ~r0, 0, rd, er);
    txn(0, 3'd0, 32'h50, 0, 0, rd, er);
    chk("store_after_load", rd, ~r0);

    req_valid = 1; mem_write = 1; dm_type = 3'd0; addr = 32'h40; wdata = 32'h12345678; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    rstn = 0;
    #1;
    chk("rst_access_rsp_valid", rsp_valid, 0);
    chk("rst_access_req_ready", req_ready, 1);
    #2 rstn = 1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    txn(0, 3'd0, 32'h40, 0, 0, rd, er);

    req_valid = 1; mem_write = 0; dm_type = 3'd0; addr = 32'h44; rsp_ready = 0;
    rd = mdl(0, 3'd0, 32'h44, 0, e);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_rdata", rdata, rd);
    rstn = 0;
    #1;
    chk("rst_resp_rsp_valid", rsp_valid, 0);
    chk("rst_resp_rdata", rdata, 0);
    chk("rst_resp_rsp_err", rsp_err, 0);
    #2 rstn = 1;
    @(negedge clk);

    for (int n = 0; n < 300; n++)
      txn(1'($urandom_range(0, 1)), $urandom_range(0, 9) > 7 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
          $urandom(), $urandom(), $urandom_range(0, 2), rd, er);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
